// File: rtl/uart_rx_frontend.sv
// Oversampling UART receiver: 16x s_tick, mid-bit sampling, glitch-rejecting start detect.
// Optional parity stage compiled in with `define UART_RX_PARITY_EN.
module uart_rx_frontend #(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned SB_TICK    = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err,
    output logic            parity_err
);

    localparam int unsigned SW = (SB_TICK > 16) ? 5 : 4;
    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_HALF = SW'(7);
    localparam logic [SW-1:0] S_BIT  = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic            rx_meta;
    logic            rxs;
    logic            rx_prev;

    state_t          state;
    state_t          state_nx;
    logic [SW-1:0]   s_cnt;
    logic [SW-1:0]   s_cnt_nx;
    logic [NW-1:0]   n_cnt;
    logic [NW-1:0]   n_cnt_nx;
    logic [DBIT-1:0] b_reg;
    logic [DBIT-1:0] b_nx;
    logic [DBIT-1:0] dout_nx;
    logic            frame_err_nx;
    logic            done_nx;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0);

    logic par_bad;
    logic par_bad_nx;
    logic parity_err_nx;
`endif

    // Two-flop synchroniser plus previous-value register for falling-edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rx_prev <= rxs;
        end
    end

    // Frame state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            s_cnt        <= '0;
            n_cnt        <= '0;
            b_reg        <= '0;
            dout         <= '0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            state        <= state_nx;
            s_cnt        <= s_cnt_nx;
            n_cnt        <= n_cnt_nx;
            b_reg        <= b_nx;
            dout         <= dout_nx;
            frame_err    <= frame_err_nx;
            rx_done_tick <= done_nx;
`ifdef UART_RX_PARITY_EN
            par_bad      <= par_bad_nx;
            parity_err   <= parity_err_nx;
`endif
        end
    end

    // Next-state and datapath updates; counters only move on s_tick.
    always_comb begin
        state_nx      = state;
        s_cnt_nx      = s_cnt;
        n_cnt_nx      = n_cnt;
        b_nx          = b_reg;
        dout_nx       = dout;
        frame_err_nx  = frame_err;
        done_nx       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nx    = par_bad;
        parity_err_nx = parity_err;
`endif

        case (state)
            IDLE: begin
                if (rx_prev && !rxs) begin
                    s_cnt_nx = '0;
                    state_nx = START;
                end
            end

            START: begin
                if (s_tick) begin
                    if (s_cnt == S_HALF) begin
                        if (!rxs) begin
                            state_nx = DATA;
                            s_cnt_nx = '0;
                            n_cnt_nx = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        s_cnt_nx = s_cnt + SW'(1);
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (s_cnt == S_BIT) begin
                        b_nx     = {rxs, b_reg[DBIT-1:1]};
                        s_cnt_nx = '0;
                        if (n_cnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_nx = PARITY;
`else
                            state_nx = STOP;
`endif
                        end else begin
                            n_cnt_nx = n_cnt + NW'(1);
                        end
                    end else begin
                        s_cnt_nx = s_cnt + SW'(1);
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt == S_BIT) begin
                        par_bad_nx = (^b_reg) ^ rxs ^ PAR_SENSE;
                        s_cnt_nx   = '0;
                        state_nx   = STOP;
                    end else begin
                        s_cnt_nx = s_cnt + SW'(1);
                    end
                end
            end
`endif

            STOP: begin
                if (s_tick) begin
                    if (s_cnt == S_STOP) begin
                        dout_nx       = b_reg;
                        frame_err_nx  = ~rxs;
`ifdef UART_RX_PARITY_EN
                        parity_err_nx = par_bad;
`endif
                        done_nx       = 1'b1;
                        state_nx      = IDLE;
                    end else begin
                        s_cnt_nx = s_cnt + SW'(1);
                    end
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

`ifndef UART_RX_PARITY_EN
    // Parity sense has no effect without the parity stage.
    if (PARITY_ODD > 1) begin : g_parity_odd_range
    end

    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Oversampling UART receiver that turns the serial `rx` line into parallel bytes for the RX FIFO inside the UART core, which in turn feeds the command interface and ALU. It synchronises the asynchronous line and detects start bits on a falling edge, rejecting glitches. It samples each bit at its midpoint using a 16x baud tick from the baud-rate generator. Each frame produces a one-cycle completion pulse with data and a framing-error flag.

## Interface
- `DBIT`, 8: data bits per frame, LSB first.
- `SB_TICK`, 16: s_ticks in the stop period; 16/24/32 give 1/1.5/2 stop bits.
- `PARITY_ODD`, 0: parity sense when parity is compiled in. 0 = even, 1 = odd.
- `clk` in 1: single clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `rx` in 1: asynchronous serial line; idle level is high.
- `s_tick` in 1: one-`clk` pulse at 16x the baud rate.
- `rx_done_tick` out 1: one-`clk` pulse when a frame completes.
- `dout` out DBIT: last received data word, held until the next `rx_done_tick`.
- `frame_err` out 1: stop bit sampled low on the last frame; held like `dout`.
- `parity_err` out 1: parity mismatch on the last frame; held like `dout`; tied 0 when parity is not compiled in.

## Operation
- **Input synchroniser:** two flip-flops on `rx`, both reset to 1. A third register `rx_prev` holds the previous synchronised value. All decisions use the synchronised value `rxs`.
- **Counters:** tick counter `s_cnt` (4 bits), bit index `n_cnt` (ceil(log2 DBIT) bits), and shift register `b_reg` (DBIT bits). The tick and bit counters advance only in cycles where `s_tick`=1.
- **IDLE:** a falling edge (`rx_prev`=1, `rxs`=0) clears `s_cnt` and moves to START. Edge detection, not level detection, means a line held low after a frame never retriggers.
- **START:** on each `s_tick`, `s_cnt` increments.
  - At `s_cnt`==7 with `s_tick`: if `rxs`=0, go to DATA with `s_cnt`=0 and `n_cnt`=0.
  - Otherwise the start was a glitch: return to IDLE with no output change.
- **DATA:** at `s_cnt`==15 with `s_tick`:
  - `b_reg` <= {`rxs`, `b_reg`[DBIT-1:1]} and `s_cnt` <= 0.
  - If `n_cnt`==DBIT-1, go to PARITY (when compiled in) or STOP; otherwise increment `n_cnt`.
- **PARITY** (only with the macro): at `s_cnt`==15 with `s_tick`, latch `par_bad` = (^`b_reg` ^ `rxs` ^ `PARITY_ODD`), then go to STOP.
- **STOP:** at `s_cnt`==SB_TICK-1 with `s_tick`, complete the frame in one step:
  - `dout` <= `b_reg`, `frame_err` <= ~`rxs`, `parity_err` <= `par_bad`;
  - pulse `rx_done_tick` and return to IDLE.
- **Framing error:** the frame still completes and pulses `rx_done_tick`, with `frame_err`=1 and `dout` carrying the shifted bits.
- **Frame arrival:** frames arrive at most once per ~10 bit times. There is no backpressure and no full input; consumers must take data on `rx_done_tick`.

## Timing
- **Reset values:** state IDLE, all counters 0, synchroniser and `rx_prev` = 1, `dout`=0, `rx_done_tick`=0, `frame_err`=0, `parity_err`=0.
- **Reset mid-frame:** the partial frame is discarded, no `rx_done_tick` is produced, and `dout`/flags return to 0.
- **Start detection:** the falling edge reaches `rxs` 2 `clk` after `rx` changes, and START is entered on the next edge.
- **Sample points:** the start bit is sampled 8 ticks after the edge. Each data bit is sampled 16 ticks after the previous sample, which is mid-bit. The stop level is sampled at the final stop tick.
- **Completion pulse:** `rx_done_tick` is registered and goes high in the `clk` cycle after the edge that consumed the final stop `s_tick`. `dout` and the flags update on that same edge.
- **Frame length (8N1, SB_TICK=16):** the edge is detected, then 8 + 8·16 + 16 = 152 s_ticks later `rx_done_tick` fires, at mid stop bit.
- **Back-to-back frames:** a falling edge arriving in the same cycle IDLE is entered is accepted. There is no dead time between frames.
- **Tick counter wrap:** `s_cnt` wraps 15 to 0 only via an explicit clear. For SB_TICK > 16, STOP uses a 5-bit compare: `s_cnt` widens to 5 bits when SB_TICK > 16.

## Configuration
- **`UART_RX_PARITY_EN` defined:** a PARITY state follows DATA and the frame gains one bit. `parity_err` reports a mismatch against `PARITY_ODD`.
- **`UART_RX_PARITY_EN` undefined:** DATA goes directly to STOP, `par_bad` logic is absent, and `parity_err` is constant 0.

## Test plan
- **Basic byte:** s_tick every 4 clk; send 0xA5 8N1 → exactly one `rx_done_tick`, `dout`=0xA5, `frame_err`=0, `parity_err`=0.
- **Glitch rejection:** `rx` low for 4 s_ticks, then high → no `rx_done_tick`, FSM back in IDLE, `dout` unchanged; a following 0x3C frame is received correctly.
- **Framing error:** 0x3C with the stop bit driven 0 and `rx` left low → `rx_done_tick`, `dout`=0x3C, `frame_err`=1. No further frame until `rx` rises and falls again.
- **Back-to-back:** 0x00, 0xFF, 0x81 with one stop bit each and no idle gap → three pulses, in order, with correct values.
- **Reset mid-frame:** `reset` asserted for 1 clk after 4 data bits of 0x55 → no pulse, `dout`=0. Then 0xC3 is received correctly.
- **Parity** (`UART_RX_PARITY_EN`, even): 0x07 with parity bit 1 → `parity_err`=0; 0x07 with parity bit 0 → `parity_err`=1.
